disp_scan: RTL and testbench
============================

Name: disp_scan

Overview:
- Consumer end of the display clock path: samples the toggling divided display clock produced by the clock divider, converts each of its edges into a one-cycle scan tick, and time-multiplexes NUM_DIGITS hex digits onto a shared 7-segment bus with one-hot digit enables.
- Sits between the authentication core's digit/status registers and the board display pins.
- Runs entirely in the fast system clock domain; the divided clock is treated as data, never as a clock.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs active-low, 0 = active-high.
- AN_ACTIVE_LOW, 1, 1 = digit enables active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- disp_tick_in  in  1  toggling divided display clock; asynchronous to the logic, treated as data.
- enable  in  1  scan enable; low blanks the display.
- digits_in  in  4*NUM_DIGITS  hex nibbles; digit 0 in bits [3:0].
- dp_in  in  NUM_DIGITS  decimal point per digit.
- seg  out  7  segments; seg[0]=a ... seg[6]=g.
- dp  out  1  decimal point for the active digit.
- an  out  NUM_DIGITS  one-hot digit enable.
- scan_idx  out  clog2(NUM_DIGITS)  index of the displayed digit.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high on rst; all flops are reset by it.
- Input synchronizer: disp_tick_in passes through a 2-flop synchronizer, then a previous-value flop.
  - tick = sync XOR prev, so both edges count (one tick per DISP clk cycles).
  - Latency: tick asserts 3 clk after a disp_tick_in transition, for exactly 1 cycle.
  - A held level produces no further ticks.
- Reset values:
  - Synchronizer flops and previous-value flop: 0.
  - FSM: IDLE.
  - scan_idx: 0.
  - an: all off.
  - seg and dp: all off (7'h7F / 1 when active-low).
  - frame_done: 0.
  - Snapshot register: 0.
- FSM states: IDLE, SHOW, BLANK. BLANK is reachable only with SCAN_BLANK_EN.
  - IDLE:
    - Outputs are off.
    - On tick with enable=1: capture snapshot of digits_in/dp_in, set scan_idx=0, go to SHOW.
  - SHOW:
    - an drives one-hot scan_idx.
    - seg shows decode(snapshot[scan_idx]); dp shows snapshot dp.
    - On tick: advance scan_idx, or go to BLANK when SCAN_BLANK_EN is defined.
  - Advance rule:
    - scan_idx = NUM_DIGITS-1 wraps to 0.
    - In the wrap cycle, frame_done pulses for 1 cycle and the snapshot is reloaded from digits_in/dp_in.
- Snapshot rule: displayed data changes only at a frame boundary. Mid-frame changes to digits_in are invisible until the next frame.
- Outputs are registered: they update 1 clk after the tick cycle, so total latency is 4 clk from the disp_tick_in edge.
- enable=0: the next clk forces IDLE, outputs off, scan_idx=0, and frame_done=0, regardless of any tick in the same cycle.
- Simultaneous events:
  - rst overrides everything.
  - enable=0 overrides tick.
- Decode: standard hex 0-F table with active-high codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Codes are inverted when SEG_ACTIVE_LOW=1.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - SHOW goes to BLANK on tick; BLANK goes to SHOW(next idx) on tick.
  - In BLANK, an, seg and dp are all off. This is one blank tick between digits for anti-ghosting.
  - frame_done and the snapshot reload occur on the BLANK to SHOW(0) transition.
  - A frame takes 2*NUM_DIGITS ticks.
- Not defined:
  - BLANK is absent; SHOW advances directly.
  - A frame takes NUM_DIGITS ticks.

Decomposition:
- Shared package disp_pkg:
  - Scan state enum (IDLE/SHOW/BLANK).
  - 16-entry 7-bit segment code constant table.
  - SEG_OFF constant.
- One combinational sub-module: seg7_decode (4-bit nibble in, 7-bit active-high code out). disp_scan applies polarity.

Test Plan:
- Reset: assert rst 2 clk with disp_tick_in toggling -> an=4'b1111, seg=7'h7F, dp=1, scan_idx=0, frame_done=0.
- Tick: enable=1, one disp_tick_in transition, then hold -> exactly one IDLE to SHOW; an=4'b1110 4 clk after the edge; no further change while held.
- Full scan: digits_in=16'h1A2F, dp_in=0, 4 further edges -> seg sequence 7'h0E, 7'h24, 7'h08, 7'h79 with an 1110, 1101, 1011, 0111; frame_done pulses once on the wrap to 1110.
- Snapshot: change digits_in to 16'h0000 while showing digit 1 -> digits 2 and 3 still show A and 1; digit 0 shows 0 (7'h40) only after frame_done.
- Enable drop at digit 2, coincident with a tick -> next clk an=1111, scan_idx=0, no frame_done. Re-enable plus tick -> resumes at digit 0 with a fresh snapshot.
- SCAN_BLANK_EN build, same 16'h1A2F stimulus -> 8 ticks per frame alternating digit/blank (blank: an=1111, seg=7'h7F); frame_done pulses on the 8th tick.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display scanner.
//   scan_state_e : scan FSM states (IDLE / SHOW / BLANK)
//   SEG_TABLE    : active-high 7-segment codes for hex 0..F, bit 0 = segment a
//   SEG_OFF      : active-high code for an unlit digit
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry 15 is listed first: packed index 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/disp_scan_seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high 7-segment code.
//   nibble_i : hex digit 0..F
//   code_o   : segments a..g in bits 0..6, 1 = lit
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] code_o
);

  assign code_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/disp_scan.sv
// disp_scan: turns edges of the divided display clock into scan ticks and
// time-multiplexes NUM_DIGITS hex digits onto a shared 7-segment bus.
//   clk, rst      : system clock, synchronous active-high reset
//   disp_tick_in  : toggling divided display clock, sampled as data
//   enable        : scan enable, low blanks the display
//   digits_in     : hex nibbles, digit 0 in bits [3:0]
//   dp_in         : decimal point per digit
//   seg, dp       : segment bus and decimal point of the active digit
//   an            : one-hot digit enable
//   scan_idx      : index of the displayed digit
//   frame_done    : one-cycle pulse when the scan wraps to digit 0
// Optional build macro SCAN_BLANK_EN inserts one blank tick between digits.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_tick_in,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_RST = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_RST  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_RST  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                            : {NUM_DIGITS{1'b0}};

  logic sync1_q, sync2_q, prev_q, tick_q;

  scan_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIG_W-1:0]         snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]    snap_dp_q, snap_dp_d;
  logic                     frame_d;

  logic [3:0]               nibble_sel;
  logic                     dp_sel;
  logic [NUM_DIGITS-1:0]    an_hot;
  logic [6:0]               code;

  logic [6:0]               seg_d, seg_q;
  logic                     dp_d, dp_q;
  logic [NUM_DIGITS-1:0]    an_d, an_q;
  logic                     frame_done_q;

  // Two-flop synchronizer plus previous-value flop; both edges yield a tick.
  // The tick is registered so outputs land 4 clk after the input edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= disp_tick_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q ^ prev_q;
    end
  end

  // Scan FSM next state; enable low wins over a same-cycle tick.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    frame_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SHOW;
          idx_d      = '0;
          snap_dig_d = digits_in;
          snap_dp_d  = dp_in;
        end
        ST_SHOW: begin
`ifdef SCAN_BLANK_EN
          state_d = ST_BLANK;
`else
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            frame_d    = 1'b1;
            snap_dig_d = digits_in;
            snap_dp_d  = dp_in;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
`endif
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          state_d = ST_SHOW;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            frame_d    = 1'b1;
            snap_dig_d = digits_in;
            snap_dp_d  = dp_in;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Select the digit that will be shown next cycle.
  always_comb begin
    nibble_sel = '0;
    dp_sel     = 1'b0;
    an_hot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble_sel = snap_dig_d[4*i +: 4];
        dp_sel     = snap_dp_d[i];
        an_hot[i]  = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (nibble_sel),
    .code_o   (code)
  );

  // Output values with board polarity applied; dark outside SHOW.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    an_d  = '0;
    if (state_d == ST_SHOW) begin
      seg_d = code;
      dp_d  = dp_sel;
      an_d  = an_hot;
    end
    if (SEG_ACTIVE_LOW) begin
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
    if (AN_ACTIVE_LOW) begin
      an_d = ~an_d;
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      seg_q        <= SEG_RST;
      dp_q         <= DP_RST;
      an_q         <= AN_RST;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign scan_idx   = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: self-checking bench for disp_scan against a frame-position model.
module tb_disp_scan;

  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = $clog2(N);
  localparam bit          SAL   = 1'b1;
  localparam bit          AAL   = 1'b1;
`ifdef SCAN_BLANK_EN
  localparam bit          BLANK = 1'b1;
`else
  localparam bit          BLANK = 1'b0;
`endif
  localparam int          STEPS = BLANK ? 2 * N : N;
  localparam int          PER   = STEPS / N;
  localparam int unsigned VW    = 7 + 1 + N + IDX_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             disp_tick_in;
  logic             enable;
  logic [4*N-1:0]   digits_in;
  logic [N-1:0]     dp_in;
  logic [6:0]       seg;
  logic             dp;
  logic [N-1:0]     an;
  logic [IDX_W-1:0] scan_idx;
  logic             frame_done;
  logic [VW-1:0]    obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: active flag, position within the frame, frame snapshot.
  bit             m_active;
  int             m_pos;
  logic [4*N-1:0] m_dig;
  logic [N-1:0]   m_dp;

  always #5 clk = ~clk;

  disp_scan #(
    .NUM_DIGITS     (N),
    .SEG_ACTIVE_LOW (SAL),
    .AN_ACTIVE_LOW  (AAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_tick_in (disp_tick_in),
    .enable       (enable),
    .digits_in    (digits_in),
    .dp_in        (dp_in),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .scan_idx     (scan_idx),
    .frame_done   (frame_done)
  );

  assign obs = {seg, dp, an, scan_idx, frame_done};

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [VW-1:0] model_vec(input bit fd);
    logic [6:0]       s;
    logic             d;
    logic [N-1:0]     a;
    logic [IDX_W-1:0] ix;
    int               digit;
    digit = BLANK ? m_pos / 2 : m_pos;
    s = 7'h00; d = 1'b0; a = '0; ix = '0;
    if (m_active) begin
      ix = IDX_W'(digit);
      if (!(BLANK && (m_pos % 2) == 1)) begin
        s = hex7(m_dig[digit*4 +: 4]);
        d = m_dp[digit];
        a[digit] = 1'b1;
      end
    end
    if (SAL) begin s = ~s; d = ~d; end
    if (AAL) a = ~a;
    return {s, d, a, ix, fd};
  endfunction

  task automatic model_tick(output bit fd);
    fd = 1'b0;
    if (!m_active) begin
      m_active = 1'b1; m_pos = 0; m_dig = digits_in; m_dp = dp_in;
    end else begin
      m_pos++;
      if (m_pos == STEPS) begin
        m_pos = 0; fd = 1'b1; m_dig = digits_in; m_dp = dp_in;
      end
    end
  endtask

  // Toggle the display clock at a negedge, then wait to 3 clk after it.
  task automatic toggle_tick();
    @(negedge clk) disp_tick_in = ~disp_tick_in;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; disp_tick_in = 1'b0;
    digits_in = '0; dp_in = '0; m_active = 1'b0; m_pos = 0; m_dig = '0; m_dp = '0;
    @(negedge clk) disp_tick_in = 1'b1;
    @(negedge clk) disp_tick_in = 1'b0;
    n_checks++; if (an !== {N{1'b1}}) begin n_fail++; $display("FAIL reset_an: got %b expected %b", an, {N{1'b1}}); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp); end
    n_checks++; if (scan_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", scan_idx); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tick();
    logic [VW-1:0] exp;
    bit fd;
    digits_in = 16'h1A2F; dp_in = '0; enable = 1'b1;
    @(negedge clk);
    toggle_tick();
    exp = model_vec(1'b0);
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL tick_latency3: got %h expected %h", obs, exp); end
    @(negedge clk); model_tick(fd); exp = model_vec(fd);
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL tick_an: got %b expected 1110", an); end
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL tick_latency4: got %h expected %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); exp = model_vec(1'b0);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL tick_hold[%0d]: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_full_scan();
    logic [VW-1:0] exp;
    bit fd;
    int frames;
    frames = 0;
    for (int k = 0; k < STEPS; k++) begin
      toggle_tick();
      exp = model_vec(1'b0);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL scan_pre[%0d]: got %h expected %h", k, obs, exp); end
      @(negedge clk); model_tick(fd); exp = model_vec(fd);
      if (frame_done === 1'b1) frames++;
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL scan_step[%0d]: got %h expected %h", k, obs, exp); end
      @(negedge clk); exp = model_vec(1'b0);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL scan_post[%0d]: got %h expected %h", k, obs, exp); end
    end
    n_checks++; if (frames !== 1) begin n_fail++; $display("FAIL scan_frames: got %0d expected 1", frames); end
  endtask

  task automatic test_snapshot();
    logic [VW-1:0] exp;
    bit fd;
    for (int k = 0; k < STEPS; k++) begin
      if (k == PER) digits_in = 16'h0000;
      toggle_tick();
      @(negedge clk); model_tick(fd); exp = model_vec(fd);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL snap_step[%0d]: got %h expected %h", k, obs, exp); end
    end
    n_checks++; if (seg !== 7'h40) begin n_fail++; $display("FAIL snap_digit0_zero: got %h expected 40", seg); end
  endtask

  task automatic test_enable_drop();
    logic [VW-1:0] exp;
    bit fd;
    for (int k = 0; k < 2 * PER; k++) begin
      toggle_tick();
      @(negedge clk); model_tick(fd);
    end
    exp = model_vec(1'b0);
    n_checks++; if (scan_idx !== 2'd2 || obs !== exp) begin n_fail++; $display("FAIL drop_at_digit2: got %h expected %h", obs, exp); end
    toggle_tick();
    enable = 1'b0;
    @(negedge clk); m_active = 1'b0; m_pos = 0; exp = model_vec(1'b0);
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL drop_coincident: got %h expected %h", obs, exp); end
    repeat (2) @(negedge clk);
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL drop_hold: got %h expected %h", obs, exp); end
    digits_in = 16'h7B3C; dp_in = 4'b0101; enable = 1'b1;
    toggle_tick();
    @(negedge clk); model_tick(fd); exp = model_vec(fd);
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL drop_resume: got %h expected %h", obs, exp); end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp;
    bit fd;
    int op;
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 7));
      if (op < 6) begin
        if ($urandom_range(0, 2) == 0) begin digits_in = 16'($urandom); dp_in = N'($urandom); end
        toggle_tick();
        @(negedge clk); model_tick(fd); exp = model_vec(fd);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rand_step[%0d]: got %h expected %h", it, obs, exp); end
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk); exp = model_vec(1'b0);
          n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h expected %h", it, obs, exp); end
        end
      end else if (op == 6) begin
        enable = 1'b0;
        @(negedge clk); m_active = 1'b0; m_pos = 0; exp = model_vec(1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rand_disable[%0d]: got %h expected %h", it, obs, exp); end
        enable = 1'b1;
      end else begin
        digits_in = 16'($urandom); dp_in = N'($urandom);
        @(negedge clk); exp = model_vec(1'b0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rand_midframe[%0d]: got %h expected %h", it, obs, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_full_scan();
    test_snapshot();
    test_enable_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
